// File: rtl/seg_id_hazard_pipe.sv
// ID/EX pipeline register with a history-based load-use stall, ID-stage jump resolution and immediate extension.
// Define SEG_ID_STALL_STATS_EN to add saturating stall/bubble counters; otherwise both count outputs read 0.
module seg_id_hazard_pipe #(
  parameter int LEN      = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_CTRL  = 21,
  parameter int LOAD_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [LEN-1:0]     i_instruction,
  input  logic [LEN-1:0]     i_pc,
  input  logic [LEN-1:0]     i_rs_data,
  input  logic [LEN-1:0]     i_rt_data,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic               i_is_load,
  input  logic               i_uses_rt,
  input  logic               i_zero_ext,
  input  logic [1:0]         i_jump_type,
  output logic               o_valid,
  output logic [LEN-1:0]     o_pc,
  output logic [LEN-1:0]     o_rs_data,
  output logic [LEN-1:0]     o_rt_data,
  output logic [LEN-1:0]     o_imm,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic               o_stall,
  output logic               o_jump,
  output logic [LEN-1:0]     o_jump_addr,
  output logic [31:0]        o_stall_cnt,
  output logic [31:0]        o_bubble_cnt
);

  logic [NB_ADDR-1:0] id_rs, id_rt, id_rd;
  logic [LEN-1:0]     id_imm;
  logic               hazard, bubble;
  logic               unused_bits;

  logic                              valid_q, valid_d;
  logic [LEN-1:0]                    pc_q, pc_d, rs_data_q, rs_data_d;
  logic [LEN-1:0]                    rt_data_q, rt_data_d, imm_q, imm_d;
  logic [NB_ADDR-1:0]                rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [NB_CTRL-1:0]                ctrl_q, ctrl_d;
  logic [LOAD_LAT-1:0]               pend_ld_q, pend_ld_d;
  logic [LOAD_LAT-1:0][NB_ADDR-1:0]  pend_rt_q, pend_rt_d;

  assign id_rs  = i_instruction[21 +: NB_ADDR];
  assign id_rt  = i_instruction[16 +: NB_ADDR];
  assign id_rd  = i_instruction[11 +: NB_ADDR];
  assign id_imm = i_zero_ext ? {{(LEN-16){1'b0}}, i_instruction[15:0]}
                             : {{(LEN-16){i_instruction[15]}}, i_instruction[15:0]};

  assign unused_bits = ^{i_instruction[31:26], i_pc[27:0]};

  // Any load still inside the availability window whose target feeds this instruction.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (pend_ld_q[k] && (pend_rt_q[k] != '0) &&
          ((pend_rt_q[k] == id_rs) || (i_uses_rt && (pend_rt_q[k] == id_rt))))
        hazard = 1'b1;
    end
    hazard = hazard & i_valid;
  end

  assign bubble  = i_flush | hazard;
  assign o_stall = hazard & i_enable & ~i_flush;
  assign o_jump  = i_valid & i_enable & ~i_flush & ~hazard & (i_jump_type != 2'b00);

  always_comb begin
    case (i_jump_type)
      2'b01, 2'b10: o_jump_addr = {i_pc[LEN-1:28], i_instruction[25:0], 2'b00};
      2'b11:        o_jump_addr = i_rs_data;
      default:      o_jump_addr = '0;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    pend_ld_d = pend_ld_q;
    pend_rt_d = pend_rt_q;
    if (i_enable) begin
      if (bubble) begin
        valid_d   = 1'b0;
        pc_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        ctrl_d    = '0;
      end else begin
        valid_d   = i_valid;
        pc_d      = i_pc;
        rs_data_d = i_rs_data;
        rt_data_d = i_rt_data;
        imm_d     = id_imm;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        ctrl_d    = i_valid ? i_ctrl : '0;
      end
      // History only advances on enabled edges so a stall keeps its length across debug holds.
      for (int k = LOAD_LAT - 1; k > 0; k--) begin
        pend_ld_d[k] = pend_ld_q[k-1];
        pend_rt_d[k] = pend_rt_q[k-1];
      end
      pend_ld_d[0] = ~bubble & i_valid & i_is_load;
      pend_rt_d[0] = bubble ? '0 : id_rt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      pend_ld_q <= '0;
      pend_rt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      pend_ld_q <= pend_ld_d;
      pend_rt_q <= pend_rt_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_pc      = pc_q;
  assign o_rs_data = rs_data_q;
  assign o_rt_data = rt_data_q;
  assign o_imm     = imm_q;
  assign o_rs      = rs_q;
  assign o_rt      = rt_q;
  assign o_rd      = rd_q;
  assign o_ctrl    = ctrl_q;

`ifdef SEG_ID_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (o_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (i_enable && bubble && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_stall_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_id_hazard_pipe.sv
// Bench for seg_id_hazard_pipe: two instances (LOAD_LAT=1 and 2) driven in parallel and checked
// against a register-availability scoreboard; counter expectations follow SEG_ID_STALL_STATS_EN.
module tb_seg_id_hazard_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, flush, vld, is_load, uses_rt, zext;
  logic [31:0] instr, pc, rs_data, rt_data;
  logic [20:0] ctrl;
  logic [1:0]  jtype;

  logic        o_valid [2];
  logic [31:0] o_pc [2], o_rs_data [2], o_rt_data [2], o_imm [2], o_jump_addr [2];
  logic [4:0]  o_rs [2], o_rt [2], o_rd [2];
  logic [20:0] o_ctrl [2];
  logic        o_stall [2], o_jump [2];
  logic [31:0] o_stall_cnt [2], o_bubble_cnt [2];

  seg_id_hazard_pipe #(.LOAD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst_n), .i_enable(en), .i_flush(flush), .i_valid(vld),
    .i_instruction(instr), .i_pc(pc), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_ctrl(ctrl), .i_is_load(is_load), .i_uses_rt(uses_rt), .i_zero_ext(zext),
    .i_jump_type(jtype), .o_valid(o_valid[0]), .o_pc(o_pc[0]), .o_rs_data(o_rs_data[0]),
    .o_rt_data(o_rt_data[0]), .o_imm(o_imm[0]), .o_rs(o_rs[0]), .o_rt(o_rt[0]), .o_rd(o_rd[0]),
    .o_ctrl(o_ctrl[0]), .o_stall(o_stall[0]), .o_jump(o_jump[0]), .o_jump_addr(o_jump_addr[0]),
    .o_stall_cnt(o_stall_cnt[0]), .o_bubble_cnt(o_bubble_cnt[0])
  );

  seg_id_hazard_pipe #(.LOAD_LAT(2)) u_lat2 (
    .i_clk(clk), .i_rst(rst_n), .i_enable(en), .i_flush(flush), .i_valid(vld),
    .i_instruction(instr), .i_pc(pc), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_ctrl(ctrl), .i_is_load(is_load), .i_uses_rt(uses_rt), .i_zero_ext(zext),
    .i_jump_type(jtype), .o_valid(o_valid[1]), .o_pc(o_pc[1]), .o_rs_data(o_rs_data[1]),
    .o_rt_data(o_rt_data[1]), .o_imm(o_imm[1]), .o_rs(o_rs[1]), .o_rt(o_rt[1]), .o_rd(o_rd[1]),
    .o_ctrl(o_ctrl[1]), .o_stall(o_stall[1]), .o_jump(o_jump[1]), .o_jump_addr(o_jump_addr[1]),
    .o_stall_cnt(o_stall_cnt[1]), .o_bubble_cnt(o_bubble_cnt[1])
  );

  // Scoreboard: avail[d][r] = enabled edges until register r's pending load result is usable.
  int          avail [2][32];
  logic        m_valid [2];
  logic [20:0] m_ctrl [2];
  logic [31:0] m_pc [2], m_rsd [2], m_rtd [2], m_imm [2], m_scnt [2], m_bcnt [2];
  logic [4:0]  m_rs [2], m_rt [2], m_rd [2];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic m_haz(int d);
    int s = int'(instr[25:21]);
    int t = int'(instr[20:16]);
    return vld && ((s != 0 && avail[d][s] > 0) || (uses_rt && t != 0 && avail[d][t] > 0));
  endfunction

  function automatic logic m_stall(int d);
    return m_haz(d) && en && !flush;
  endfunction

  function automatic logic m_jump(int d);
    return vld && en && !flush && !m_haz(d) && (jtype != 2'b00);
  endfunction

  function automatic logic [31:0] m_jaddr();
    if (jtype == 2'b11) return rs_data;
    if (jtype == 2'b00) return 32'h0;
    return {pc[31:28], 28'(instr[25:0] * 4)};
  endfunction

  function automatic logic [31:0] e_scnt(int d);
`ifdef SEG_ID_STALL_STATS_EN
    return m_scnt[d];
`else
    return 32'h0 & m_scnt[d];
`endif
  endfunction

  function automatic logic [31:0] e_bcnt(int d);
`ifdef SEG_ID_STALL_STATS_EN
    return m_bcnt[d];
`else
    return 32'h0 & m_bcnt[d];
`endif
  endfunction

  function automatic logic [31:0] r_ins(int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h020};
  endfunction

  function automatic logic [31:0] lw(int rs, int rt);
    return {6'h23, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  // Advance the scoreboard with the inputs present before the edge, then clock.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_valid[d] = 0; m_ctrl[d] = 0; m_pc[d] = 0; m_rsd[d] = 0; m_rtd[d] = 0;
        m_imm[d] = 0; m_rs[d] = 0; m_rt[d] = 0; m_rd[d] = 0; m_scnt[d] = 0; m_bcnt[d] = 0;
        for (int r = 0; r < 32; r++) avail[d][r] = 0;
      end else if (en) begin
        logic h, bub;
        h = m_haz(d);
        bub = flush | h;
        if (bub) begin
          m_valid[d] = 0; m_ctrl[d] = 0; m_pc[d] = 0; m_rsd[d] = 0; m_rtd[d] = 0;
          m_imm[d] = 0; m_rs[d] = 0; m_rt[d] = 0; m_rd[d] = 0;
          if (m_bcnt[d] != 32'hFFFF_FFFF) m_bcnt[d] = m_bcnt[d] + 1;
          if (h && !flush && m_scnt[d] != 32'hFFFF_FFFF) m_scnt[d] = m_scnt[d] + 1;
        end else begin
          m_valid[d] = vld; m_ctrl[d] = vld ? ctrl : 21'h0;
          m_pc[d] = pc; m_rsd[d] = rs_data; m_rtd[d] = rt_data;
          m_imm[d] = zext ? 32'(instr[15:0]) : 32'($signed(instr[15:0]));
          m_rs[d] = instr[25:21]; m_rt[d] = instr[20:16]; m_rd[d] = instr[15:11];
        end
        for (int r = 0; r < 32; r++) if (avail[d][r] > 0) avail[d][r]--;
        if (!bub && vld && is_load) avail[d][instr[20:16]] = d + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic ld, input logic urt);
    vld = v; instr = ins; is_load = ld; uses_rt = urt;
    flush = 0; en = 1; zext = 0; jtype = 2'b00;
    pc = $urandom; rs_data = $urandom; rt_data = $urandom; ctrl = 21'($urandom);
    #1;
  endtask

  task automatic idle();
    set_in(0, 32'h0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_in(1, lw(1, 2), 1, 1);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({o_valid[d], o_ctrl[d], o_rs[d], o_rt[d], o_rd[d], o_pc[d], o_rs_data[d], o_rt_data[d], o_imm[d]} !== '0) begin
        n_fail++; $display("FAIL reset_regs d%0d: got valid=%b ctrl=%h pc=%h imm=%h want all 0", d, o_valid[d], o_ctrl[d], o_pc[d], o_imm[d]);
      end
      n_checks++;
      if ({o_stall_cnt[d], o_bubble_cnt[d]} !== 64'h0) begin
        n_fail++; $display("FAIL reset_cnt d%0d: got %h/%h want 0/0", d, o_stall_cnt[d], o_bubble_cnt[d]);
      end
    end
    rst_n = 1;
    set_in(1, r_ins(2, 2, 3), 0, 1);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_stall[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_history d%0d: got stall=%b want 0", d, o_stall[d]);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    int n0 = 0;
    int n1 = 0;
    idle();
    set_in(1, lw(1, 2), 1, 0);
    tick();
    set_in(1, r_ins(2, 4, 3), 0, 1);
    for (int c = 0; c < 8 && (o_stall[0] || o_stall[1]); c++) begin
      n0 += int'(o_stall[0]);
      n1 += int'(o_stall[1]);
      tick();
      if (c == 0) begin
        n_checks++;
        if ({o_valid[0], o_ctrl[0]} !== 22'h0) begin
          n_fail++; $display("FAIL lat1_bubble: got valid=%b ctrl=%h want 0/0", o_valid[0], o_ctrl[0]);
        end
      end
    end
    n_checks++;
    if (n0 != 1 || n1 != 2) begin
      n_fail++; $display("FAIL load_use_len: got %0d/%0d want 1/2", n0, n1);
    end
    n_checks++;
    if (o_valid[0] !== 1'b1 || o_rs[0] !== 5'd2) begin
      n_fail++; $display("FAIL lat1_capture: got valid=%b rs=%0d want 1/2", o_valid[0], o_rs[0]);
    end
    tick();
    n_checks++;
    if (o_valid[1] !== 1'b1 || o_rs[1] !== 5'd2) begin
      n_fail++; $display("FAIL lat2_capture: got valid=%b rs=%0d want 1/2", o_valid[1], o_rs[1]);
    end
  endtask

  task automatic test_rt_dep();
    for (int gap = 0; gap < 2; gap++) begin
      int n0 = 0;
      int n1 = 0;
      idle();
      set_in(1, lw(1, 5), 1, 0);
      tick();
      if (gap == 1) begin
        set_in(1, r_ins(9, 10, 11), 0, 1);
        tick();
      end
      set_in(1, r_ins(1, 5, 6), 0, 1);
      for (int c = 0; c < 8 && (o_stall[0] || o_stall[1]); c++) begin
        n0 += int'(o_stall[0]);
        n1 += int'(o_stall[1]);
        tick();
      end
      n_checks++;
      if (n0 != 1 - gap || n1 != 2 - gap) begin
        n_fail++; $display("FAIL rt_dep_gap%0d: got %0d/%0d want %0d/%0d", gap, n0, n1, 1 - gap, 2 - gap);
      end
      tick();
    end
  endtask

  task automatic test_no_hazard();
    logic [31:0] lds [3] = '{lw(1, 0), lw(1, 7), lw(1, 7)};
    logic [31:0] uses [3] = '{r_ins(0, 0, 1), r_ins(8, 8, 1), r_ins(1, 7, 2)};
    logic        urt [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      idle();
      set_in(1, lds[i], 1, 0);
      tick();
      set_in(1, uses[i], 0, urt[i]);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_stall[d] !== 1'b0) begin
          n_fail++; $display("FAIL no_hazard_%0d d%0d: got stall=%b want 0", i, d, o_stall[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_jump();
    idle();
    for (int jt = 1; jt < 3; jt++) begin
      set_in(1, {6'h02, 26'h0000010}, 0, 0);
      pc = 32'hA000_0004; jtype = 2'(jt);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_jump[d] !== 1'b1 || o_jump_addr[d] !== 32'hA000_0040) begin
          n_fail++; $display("FAIL jump_j%0d d%0d: got jump=%b addr=%h want 1/a0000040", jt, d, o_jump[d], o_jump_addr[d]);
        end
      end
      tick();
    end
    set_in(1, r_ins(9, 0, 0), 0, 0);
    jtype = 2'b11; rs_data = 32'h1234;
    #1;
    n_checks++;
    if (o_jump[0] !== 1'b1 || o_jump_addr[0] !== 32'h1234) begin
      n_fail++; $display("FAIL jump_jr: got jump=%b addr=%h want 1/00001234", o_jump[0], o_jump_addr[0]);
    end
    idle();
    set_in(1, lw(1, 9), 1, 0);
    tick();
    set_in(1, r_ins(9, 0, 0), 0, 0);
    jtype = 2'b11; rs_data = 32'h1234;
    #1;
    n_checks++;
    if (o_jump[0] !== 1'b0 || o_jump[1] !== 1'b0) begin
      n_fail++; $display("FAIL jr_stalled: got %b/%b want 0/0", o_jump[0], o_jump[1]);
    end
    tick();
    n_checks++;
    if (o_jump[0] !== 1'b1 || o_jump[1] !== 1'b0) begin
      n_fail++; $display("FAIL jr_release1: got %b/%b want 1/0", o_jump[0], o_jump[1]);
    end
    tick();
    n_checks++;
    if (o_jump[1] !== 1'b1) begin
      n_fail++; $display("FAIL jr_release2: got %b want 1", o_jump[1]);
    end
    tick();
  endtask

  task automatic test_flush_hold_reset();
    logic [63:0] saved [2];
    idle();
    set_in(1, lw(1, 3), 1, 0);
    tick();
    set_in(1, r_ins(3, 0, 4), 0, 0);
    flush = 1;
    #1;
    n_checks++;
    if (o_stall[0] !== 1'b0 || o_stall[1] !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b/%b want 0/0", o_stall[0], o_stall[1]);
    end
    tick();
    n_checks++;
    if ({o_valid[0], o_ctrl[0], o_valid[1], o_ctrl[1]} !== 44'h0) begin
      n_fail++; $display("FAIL flush_bubble: got valid=%b/%b want 0/0", o_valid[0], o_valid[1]);
    end
    set_in(1, r_ins(3, 0, 4), 0, 0);
    en = 0;
    #1;
    for (int d = 0; d < 2; d++) saved[d] = {o_valid[d], o_ctrl[d], o_pc[d][31:22], o_rd[d], o_rs[d], o_imm[d][15:0]};
    n_checks++;
    if (o_stall[0] !== 1'b0 || o_stall[1] !== 1'b0) begin
      n_fail++; $display("FAIL hold_stall: got %b/%b want 0/0", o_stall[0], o_stall[1]);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({o_valid[d], o_ctrl[d], o_pc[d][31:22], o_rd[d], o_rs[d], o_imm[d][15:0]} !== saved[d]) begin
        n_fail++; $display("FAIL hold_regs d%0d: got valid=%b pc=%h rd=%0d want unchanged", d, o_valid[d], o_pc[d], o_rd[d]);
      end
    end
    en = 1;
    #1;
    n_checks++;
    if (o_stall[0] !== 1'b0 || o_stall[1] !== 1'b1) begin
      n_fail++; $display("FAIL hold_history: got %b/%b want 0/1", o_stall[0], o_stall[1]);
    end
    rst_n = 0;
    tick();
    n_checks++;
    if ({o_valid[1], o_ctrl[1], o_pc[1], o_rs[1]} !== '0) begin
      n_fail++; $display("FAIL midstall_reset: got valid=%b pc=%h want 0", o_valid[1], o_pc[1]);
    end
    rst_n = 1;
    #1;
    n_checks++;
    if (o_stall[1] !== 1'b0) begin
      n_fail++; $display("FAIL reset_clears_history: got %b want 0", o_stall[1]);
    end
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] want [2] = '{32'hFFFF_8001, 32'h0000_8001};
    for (int z = 0; z < 2; z++) begin
      set_in(1, {6'h08, 5'd1, 5'd2, 16'h8001}, 0, 0);
      zext = 1'(z);
      tick();
      n_checks++;
      if (o_imm[0] !== want[z]) begin
        n_fail++; $display("FAIL imm_zext%0d: got %h want %h", z, o_imm[0], want[z]);
      end
    end
  endtask

  task automatic test_stats();
    logic [31:0] ws [2] = '{32'd1, 32'd2};
    logic [31:0] wb [2] = '{32'd2, 32'd3};
    rst_n = 0;
    set_in(0, 32'h0, 0, 0);
    tick();
    rst_n = 1;
    set_in(1, lw(1, 2), 1, 0);
    tick();
    set_in(1, r_ins(2, 4, 3), 0, 1);
    tick();
    tick();
    flush = 1;
    tick();
    for (int d = 0; d < 2; d++) begin
`ifndef SEG_ID_STALL_STATS_EN
      ws[d] = 0; wb[d] = 0;
`endif
      n_checks++;
      if (o_stall_cnt[d] !== ws[d] || o_bubble_cnt[d] !== wb[d]) begin
        n_fail++; $display("FAIL stats d%0d: got %0d/%0d want %0d/%0d", d, o_stall_cnt[d], o_bubble_cnt[d], ws[d], wb[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [164:0] act, exp;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 9) == 0);
      vld = ($urandom_range(0, 5) != 0);
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 3));
      instr[20:16] = 5'($urandom_range(0, 3));
      is_load = ($urandom_range(0, 2) == 0);
      uses_rt = 1'($urandom); zext = 1'($urandom); jtype = 2'($urandom);
      pc = $urandom; rs_data = $urandom; rt_data = $urandom; ctrl = 21'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_stall[d] !== m_stall(d) || o_jump[d] !== m_jump(d) || o_jump_addr[d] !== m_jaddr()) begin
          n_fail++; $display("FAIL rand_comb d%0d cyc%0d: got stall=%b jump=%b addr=%h want %b/%b/%h",
                             d, i, o_stall[d], o_jump[d], o_jump_addr[d], m_stall(d), m_jump(d), m_jaddr());
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        act = {o_valid[d], o_ctrl[d], o_pc[d], o_rs_data[d], o_rt_data[d], o_imm[d], o_rs[d], o_rt[d], o_rd[d]};
        exp = {m_valid[d], m_ctrl[d], m_pc[d], m_rsd[d], m_rtd[d], m_imm[d], m_rs[d], m_rt[d], m_rd[d]};
        n_checks++;
        if (act !== exp) begin
          n_fail++; $display("FAIL rand_regs d%0d cyc%0d: got %h want %h", d, i, act, exp);
        end
        n_checks++;
        if (o_stall_cnt[d] !== e_scnt(d) || o_bubble_cnt[d] !== e_bcnt(d)) begin
          n_fail++; $display("FAIL rand_cnt d%0d cyc%0d: got %0d/%0d want %0d/%0d",
                             d, i, o_stall_cnt[d], o_bubble_cnt[d], e_scnt(d), e_bcnt(d));
        end
      end
    end
  endtask

  initial begin
    rst_n = 0;
    test_reset();
    test_load_use();
    test_rt_dep();
    test_no_hazard();
    test_jump();
    test_flush_hold_reset();
    test_imm();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
